fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the MIPS core: owns the architectural PC register, consumes the next-PC value computed by the next-PC logic, and issues one fetch at a time to instruction memory over a request/acknowledge handshake. It holds each fetched instruction for the decode stage until decode accepts it, then advances the PC. A fetch from an illegal address raises a sticky fault.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- IMEM_LO, 32'h0000_3000, lowest legal fetch address (inclusive)
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive)

- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- npc  in  32  next PC from next-PC logic; sampled only on retire
- pc  out  32  current PC (also drives imem_addr)
- pc4  out  32  pc + 4, combinational, for link/next-PC use
- imem_req  out  1  fetch request, high only in FETCH
- imem_addr  out  32  fetch address, equals pc
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- instr_valid  out  1  instr/instr_pc valid for decode (high only in HOLD)
- instr  out  32  held instruction word
- instr_pc  out  32  address instr was fetched from
- id_ready  in  1  decode accepts instr this cycle
- fetch_fault  out  1  sticky illegal-address flag
- retire_cnt  out  32  number of instructions accepted by decode

## Operation
- States: IDLE, FETCH, HOLD, FAULT. Reset state IDLE.
- Legal(a): a[1:0]==2'b00 and IMEM_LO <= a <= IMEM_HI (unsigned).
- IDLE: all handshake outputs low; next edge -> FETCH if Legal(pc), else FAULT.
- FETCH: imem_req=1, imem_addr=pc held stable until ack. On imem_ack=1: instr<=imem_rdata, instr_pc<=pc, -> HOLD. No ack -> stay (unbounded wait).
- HOLD: instr_valid=1, instr/instr_pc stable. On id_ready=1 (retire): pc<=npc, retire_cnt<=retire_cnt+1, -> FETCH if Legal(npc), else FAULT. id_ready=0 -> stay.
- FAULT: fetch_fault=1, imem_req=0, instr_valid=0; pc holds the offending address; exits only via reset.
- imem_ack outside FETCH ignored; id_ready outside HOLD ignored (no count, no PC update).
- npc==pc (self-loop) is a normal legal retire.
- retire_cnt is 32-bit unsigned, wraps 32'hFFFF_FFFF -> 0.
- pc4 = pc + 4 modulo 2^32, no overflow flag.

## Timing
- Reset values (asserted asynchronously): pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0, retire_cnt=0.
- First imem_req: first rising edge after reset_n deasserts moves IDLE->FETCH; imem_req high in the following cycle.
- Zero-wait memory (ack in first FETCH cycle): ack at cycle t -> instr_valid at t+1; id_ready at t+1 -> pc=npc and imem_req at t+2. Peak throughput: one instruction per 2 cycles.
- Each extra memory wait cycle or decode stall cycle adds exactly one cycle.
- npc is sampled only at the retire edge; changes at other times have no effect.
- Reset mid-FETCH abandons the outstanding request: imem_req drops immediately with reset_n low; a late ack after reset is ignored (state is IDLE).
- Reset mid-HOLD discards the held instruction without counting it.

## Test plan
- Reset/boot: hold reset_n low 3 cycles, release -> cycle 1 IDLE (imem_req=0), cycle 2 imem_req=1 with imem_addr=32'h0000_3000, all other outputs at reset values.
- Sequential stream, zero-wait memory, id_ready=1, npc=pc4 -> instr_valid every 2nd cycle, instr_pc = 3000, 3004, 3008..., retire_cnt increments by 1 per valid.
- Stalls: memory acks after 3 wait cycles, decode holds id_ready=0 for 2 cycles -> imem_addr stable throughout wait, instr stable throughout hold, exactly one retire.
- Branch/jump: retire with npc=32'h0000_3400 -> next imem_addr=3400; retire with npc=pc (self-loop) -> same address refetched, count increments.
- Fault: retire with npc=32'h0000_3002, and separately npc=32'h0000_7000 -> fetch_fault=1 next cycle, pc shows offending value, imem_req stays 0 until reset clears fault.
- Async reset mid-FETCH with ack arriving the cycle after reset_n rises -> ack ignored, pc=RESET_PC, retire_cnt=0; force retire_cnt to 32'hFFFF_FFFF and retire -> wraps to 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack and decode hand-off.
// The master side is the fetch stage; the slave side is memory plus decode.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        id_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time and
// holds it for decode; an illegal fetch address parks the unit in FAULT.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  npc,
    output logic [31:0]  pc,
    output logic [31:0]  pc4,
    output logic         fetch_fault,
    output logic [31:0]  retire_cnt,
    fetch_unit_if.master fif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        FAULT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] ipc_q;
    logic [31:0] ipc_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= IMEM_LO) && (a <= IMEM_HI);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                state_d = legal(pc_q) ? FETCH : FAULT;
            end
            FETCH: begin
                if (fif.imem_ack) begin
                    instr_d = fif.imem_rdata;
                    ipc_d   = pc_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // npc only matters on the retire edge
                if (fif.id_ready) begin
                    pc_d    = npc;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = legal(npc) ? FETCH : FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
        endcase
    end

    assign pc              = pc_q;
    assign pc4             = pc_q + 32'd4;
    assign retire_cnt      = cnt_q;
    assign fetch_fault     = (state_q == FAULT);
    assign fif.imem_req    = (state_q == FETCH);
    assign fif.imem_addr   = pc_q;
    assign fif.instr_valid = (state_q == HOLD);
    assign fif.instr       = instr_q;
    assign fif.instr_pc    = ipc_q;

endmodule
